// File: rtl/cpu_pkg.sv
// Shared register-file defaults and the helper used to locate a port's
// slice inside the packed multi-port address and data buses.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;

    // Bit offset of port 'port' in a bus built from equal 'width'-bit fields.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: selects committed data or same-cycle forwarded write data,
// and reports whether the addressed register still has a pending producer.
module regfile_rdport
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              busy_bit,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);

    logic hit_s;
    logic set_hit_s;

    // Forwarding mux; reset masks the bypass path as well as the array.
    always_comb begin
        hit_s     = 1'b0;
        set_hit_s = sb_set && (sb_addr == raddr);
        if (BYPASS != 0) begin
            hit_s = wen && (waddr == raddr) && (raddr != {ADDR_W{1'b0}});
        end else begin
            hit_s = 1'b0;
        end

        rdata = {DATA_W{1'b0}};
        rbusy = 1'b0;
        if (rst || (raddr == {ADDR_W{1'b0}})) begin
            rdata = {DATA_W{1'b0}};
            rbusy = 1'b0;
        end else if (hit_s && !set_hit_s) begin
            rdata = wdata;
            rbusy = 1'b0;
        end else if (hit_s) begin
            // A new producer issued to the same register keeps it busy.
            rdata = wdata;
            rbusy = busy_bit;
        end else begin
            rdata = rf_data;
            rbusy = busy_bit;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with r0 hardwired to zero, optional write
// forwarding, and a per-register busy scoreboard with a population counter.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    output logic [ADDR_W:0]       busy_cnt,
    input  logic [ADDR_W-1:0]     test_addr,
    output logic [DATA_W-1:0]     test_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              wr_en_s;
    logic              set_en_s;
    logic              set_rise_s;
    logic              clr_fall_s;

    // Scoreboard next state: a set beats a clear on the same register.
    always_comb begin
        wr_en_s    = wen && (waddr != {ADDR_W{1'b0}});
        set_en_s   = sb_set && (sb_addr != {ADDR_W{1'b0}});
        set_rise_s = set_en_s && !busy_q[sb_addr];
        clr_fall_s = wr_en_s && busy_q[waddr] && !(set_en_s && (sb_addr == waddr));
        busy_d     = busy_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (set_en_s && (sb_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_en_s && (waddr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        busy_d[0]  = 1'b0;
        busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, set_rise_s}
                                - {{ADDR_W{1'b0}}, clr_fall_s};
    end

    // Register array, busy bits and counter; r0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= {DATA_W{1'b0}};
            end
            busy_q     <= {DEPTH{1'b0}};
            busy_cnt_q <= {(ADDR_W+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                rf_q[waddr] <= wdata;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Debug port sees committed state only.
    always_comb begin
        if (rst) begin
            test_data = {DATA_W{1'b0}};
        end else begin
            test_data = rf_q[test_addr];
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rdport
        localparam int RA_LSB = port_lsb(g, ADDR_W);
        localparam int RD_LSB = port_lsb(g, DATA_W);
        logic [ADDR_W-1:0] ra_s;
        assign ra_s = raddr[RA_LSB +: ADDR_W];

        regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rdport (
            .rst      (rst),
            .wen      (wen),
            .waddr    (waddr),
            .wdata    (wdata),
            .sb_set   (sb_set),
            .sb_addr  (sb_addr),
            .raddr    (ra_s),
            .rf_data  (rf_q[ra_s]),
            .busy_bit (busy_q[ra_s]),
            .rdata    (rdata[RD_LSB +: DATA_W]),
            .rbusy    (rbusy[g])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: the driver pushes reference-model expectations, a monitor
// compares both a forwarding and a non-forwarding instance every cycle.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic        sb_set = 1'b0;
    logic [4:0]  waddr = 5'd0, sb_addr = 5'd0, test_addr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [9:0]  raddr = 10'd0;

    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic [5:0]  cnt_b, cnt_n;
    logic [31:0] td_b, td_n;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .sb_set(sb_set),
        .sb_addr(sb_addr), .busy_cnt(cnt_b), .test_addr(test_addr), .test_data(td_b));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n), .sb_set(sb_set),
        .sb_addr(sb_addr), .busy_cnt(cnt_n), .test_addr(test_addr), .test_data(td_n));

    typedef struct {
        logic [63:0] rd_b, rd_n;
        logic [1:0]  rb_b, rb_n;
        logic [5:0]  cnt;
        logic [31:0] td;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_rf [32];
    bit          m_busy [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One stimulus cycle: drive at negedge, push expectation, advance model.
    task automatic cyc(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input bit s, input logic [4:0] sa, input logic [4:0] ta);
        exp_t        e;
        int          c;
        logic [4:0]  a;
        logic [31:0] base;
        bit          hit, bb;
        @(negedge clk);
        rst = r; wen = w; waddr = wa; wdata = wd; raddr = {ra1, ra0};
        sb_set = s; sb_addr = sa; test_addr = ta;
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            a    = (p == 1) ? ra1 : ra0;
            base = (r || a == 5'd0) ? 32'd0 : m_rf[a];
            hit  = !r && w && (wa == a) && (a != 5'd0);
            bb   = (r || a == 5'd0) ? 1'b0 : m_busy[a];
            e.rd_n[p*32 +: 32] = base;
            e.rd_b[p*32 +: 32] = hit ? wd : base;
            e.rb_n[p] = bb;
            e.rb_b[p] = (hit && !(s && sa == a)) ? 1'b0 : bb;
        end
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        e.cnt = c[5:0];
        e.td  = r ? 32'd0 : m_rf[ta];
        exp_q.push_back(e);
        if (!r) begin
            if (w && wa != 5'd0) m_rf[wa] = wd;
            if (w) m_busy[wa] = 1'b0;
            if (s && sa != 5'd0) m_busy[sa] = 1'b1;
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    // Monitor: every cycle the DUTs present outputs, compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rdata_byp", 64'(rdata_b), 64'(e.rd_b));
                check("rdata_nobyp", 64'(rdata_n), 64'(e.rd_n));
                check("rbusy_byp", 64'(rbusy_b), 64'(e.rb_b));
                check("rbusy_nobyp", 64'(rbusy_n), 64'(e.rb_n));
                check("busy_cnt_byp", 64'(cnt_b), 64'(e.cnt));
                check("busy_cnt_nobyp", 64'(cnt_n), 64'(e.cnt));
                check("test_data_byp", 64'(td_b), 64'(e.td));
                check("test_data_nobyp", 64'(td_n), 64'(e.td));
            end
        end
    end

    initial begin
        cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0);
        cyc(0, 1, 5'd5, 32'h12345678, 5'd5, 5'd0, 0, 5'd0, 5'd5);
        cyc(0, 0, 5'd0, 32'd0, 5'd5, 5'd0, 0, 5'd0, 5'd5);
        cyc(0, 1, 5'd7, 32'h11112222, 5'd0, 5'd0, 0, 5'd0, 5'd0);
        cyc(0, 1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 0, 5'd0, 5'd7);
        cyc(0, 0, 5'd0, 32'd0, 5'd0, 5'd7, 0, 5'd0, 5'd7);
        cyc(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1, 5'd0, 5'd0);
        cyc(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0);
        cyc(0, 0, 5'd0, 32'd0, 5'd3, 5'd4, 1, 5'd3, 5'd0);
        cyc(0, 0, 5'd0, 32'd0, 5'd3, 5'd4, 1, 5'd4, 5'd0);
        cyc(0, 0, 5'd0, 32'd0, 5'd3, 5'd4, 0, 5'd0, 5'd0);
        cyc(0, 1, 5'd3, 32'hCAFE0003, 5'd3, 5'd9, 1, 5'd9, 5'd3);
        cyc(0, 0, 5'd0, 32'd0, 5'd3, 5'd9, 0, 5'd0, 5'd3);
        cyc(0, 0, 5'd0, 32'd0, 5'd6, 5'd0, 1, 5'd6, 5'd0);
        cyc(0, 1, 5'd6, 32'h00C0FFEE, 5'd6, 5'd6, 1, 5'd6, 5'd6);
        cyc(0, 0, 5'd0, 32'd0, 5'd6, 5'd0, 0, 5'd0, 5'd6);
        cyc(0, 1, 5'd10, 32'h0BADF00D, 5'd10, 5'd0, 1, 5'd12, 5'd10);
        cyc(1, 1, 5'd11, 32'hDEADBEEF, 5'd10, 5'd11, 1, 5'd11, 5'd10);
        cyc(0, 0, 5'd0, 32'd0, 5'd10, 5'd11, 0, 5'd0, 5'd11);
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
                rnd_addr(), rnd_addr(), ($urandom_range(0, 2) == 0), rnd_addr(), rnd_addr());
        end
        @(negedge clk);
        #5;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding on read ports.
REQ-005 SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-006 SHALL have port clk  input  1: clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1: asynchronous active-high reset.
REQ-008 SHALL have port wen  input  1: write enable.
REQ-009 SHALL have port waddr  input  ADDR_W: write address.
REQ-010 SHALL have port wdata  input  DATA_W: write data.
REQ-011 SHALL have port raddr  input  NRD*ADDR_W: read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rdata  output  NRD*DATA_W: read data, same packing as raddr.
REQ-013 SHALL have port rbusy  output  NRD: port i's register has a pending producer.
REQ-014 SHALL have port sb_set  input  1: mark sb_addr busy (producer issued).
REQ-015 SHALL have port sb_addr  input  ADDR_W: scoreboard set address.
REQ-016 SHALL have port busy_cnt  output  ADDR_W+1: number of registers currently busy.
REQ-017 SHALL have port test_addr  input  ADDR_W: debug read address.
REQ-018 SHALL have port test_data  output  DATA_W: debug read data, never bypassed.

Function
REQ-019 SHALL write wdata to rf[waddr] on the rising clk edge when wen=1 and waddr!=0.
REQ-020 SHALL ignore writes to address 0; rf[0] reads 0 on every port at all times.
REQ-021 SHALL provide combinational reads: rdata[i] = rf[raddr[i]], with zero latency.
REQ-022 SHALL, when BYPASS=1 and wen=1 and waddr==raddr[i]!=0, drive rdata[i]=wdata in the same cycle; when BYPASS=0, SHALL return the old value until the next cycle.
REQ-023 SHALL keep a busy bit per register: sb_set sets busy[sb_addr] at the clock edge; wen clears busy[waddr] at the clock edge.
REQ-024 SHALL let the set win when sb_set and wen target the same address in the same cycle (busy stays 1, data is written).
REQ-025 SHALL ignore sb_set to address 0; busy[0] is constant 0.
REQ-026 SHALL drive rbusy[i] = busy[raddr[i]]; when BYPASS=1, SHALL force it to 0 if wen=1 and waddr==raddr[i], unless sb_set hits the same address.
REQ-027 SHALL update busy_cnt registered: +1 per 0->1 transition and -1 per 1->0 transition; it never exceeds 2**ADDR_W-1 and never underflows; if a set and a clear of different addresses coincide, the net change is 0.
REQ-028 SHALL take no action on a clear of a non-busy register (data is still written).
REQ-029 SHALL return rf[test_addr] on test_data (0 for address 0), reflecting only committed state.

Reset
REQ-030 SHALL, on rst=1, immediately clear all rf entries, all busy bits and busy_cnt to 0, independent of clk.
REQ-031 SHALL drive rdata=0, rbusy=0 and test_data=0 while rst is held, including bypass paths.
REQ-032 SHALL ignore wen and sb_set in a cycle where rst is asserted; the first update happens on the first edge after deassertion.

Structure
REQ-033 SHALL place the default DATA_W/ADDR_W/NRD values and the packing helper widths in shared package cpu_pkg.
REQ-034 SHALL implement the per-port read/bypass/busy mux as sub-module regfile_rdport, instantiated NRD times via generate.

Verification
REQ-035 SHALL check: reset, write 0x12345678 to r5, next cycle raddr0=5 -> rdata0=0x12345678, test_data(5)=0x12345678.
REQ-036 SHALL check: wen=1, waddr=7, wdata=0xA5A5A5A5, raddr1=7 in the same cycle -> rdata1=0xA5A5A5A5 with BYPASS=1, and the old value with BYPASS=0.
REQ-037 SHALL check: write 0xFFFFFFFF to r0, sb_set to r0 -> rdata=0, rbusy=0, busy_cnt=0.
REQ-038 SHALL check: sb_set r3, then r4 -> busy_cnt=2; wen r3 together with sb_set r9 -> busy_cnt=2, rbusy(r3)=0, rbusy(r9)=1.
REQ-039 SHALL check: sb_set and wen both to r6 in the same cycle -> r6 written, busy stays 1, busy_cnt unchanged.
REQ-040 SHALL check: assert rst mid-sequence between clock edges -> all outputs 0 immediately, busy_cnt=0, and a write in the same cycle is dropped.
